cdnsusbhs_load_sync_mux: RTL and testbench

- Multi-channel front end for the load synchroniser transmit path. It runs entirely in the txclk domain.
- It accepts up to CHANNELS independent load/data requests and holds one pending word per channel.
- Channels are arbitrated round-robin and serialised onto a single 4-phase req/ack CDC handshake. Each transfer carries a channel index tag.
- The downstream receive side decodes the tag. This lets several slow control registers share one synchroniser instead of one synchroniser per register.

---
 rtl/cdnsusbhs_load_sync_mux_pkg.sv | 15 +
 rtl/cdnsusbhs_rr_arbiter.sv | 31 +++
 rtl/cdnsusbhs_load_sync_mux.sv | 110 +++++++++++
 tb/tb_cdnsusbhs_load_sync_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cdnsusbhs_load_sync_mux_pkg.sv
// Shared types and default widths for the load synchroniser mux.
// State encoding 2'd3 is unused and always recovers to LSM_IDLE.
package cdnsusbhs_load_sync_mux_pkg;

  localparam int unsigned LSM_DATA_W_DEF   = 32'd8;
  localparam int unsigned LSM_CHANNELS_DEF = 32'd4;
  localparam int unsigned LSM_IDX_W_DEF    = 32'd2;

  typedef enum logic [1:0] {
    LSM_IDLE    = 2'd0,
    LSM_REQ     = 2'd1,
    LSM_ACKWAIT = 2'd2
  } lsm_state_t;

endpackage

// File: rtl/cdnsusbhs_rr_arbiter.sv
// Round-robin arbiter: the first requester after ptr wins, wrapping around; purely combinational.
// No backpressure: the grant follows req/ptr in the same cycle.
module cdnsusbhs_rr_arbiter #(
  parameter int unsigned CHANNELS = 32'd4,
  parameter int unsigned IDX_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [IDX_W-1:0]    gnt_idx
);

  int  c;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int i = 1; i <= int'(CHANNELS); i++) begin
      c = (int'(ptr) + i) % int'(CHANNELS);
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/cdnsusbhs_load_sync_mux.sv
// Serialises per-channel load words onto one tagged 4-phase req/ack CDC handshake; req rises 1 cycle after capture when idle.
// Backpressure: one pending word per channel; a repeat load raises txovf and overwrites or drops as configured.
module cdnsusbhs_load_sync_mux
  import cdnsusbhs_load_sync_mux_pkg::*;
#(
  parameter int unsigned DATA_SYNC_WIDTH = LSM_DATA_W_DEF,
  parameter int unsigned CHANNELS        = LSM_CHANNELS_DEF,
  parameter int unsigned CH_IDX_WIDTH    = LSM_IDX_W_DEF,
  parameter bit          OVERWRITE_EN    = 1'b1
) (
  input  logic                                txclk,
  input  logic                                txrst,
  input  logic [CHANNELS-1:0]                 txload,
  input  logic [CHANNELS*DATA_SYNC_WIDTH-1:0] txdata,
  output logic [CHANNELS-1:0]                 txpending,
  output logic [CHANNELS-1:0]                 txdone,
  output logic [CHANNELS-1:0]                 txovf,
  output logic                                cdc_req,
  output logic [CH_IDX_WIDTH+DATA_SYNC_WIDTH-1:0] cdc_data,
  input  logic                                cdc_ack
);

  localparam int unsigned DW = DATA_SYNC_WIDTH;

  if (CH_IDX_WIDTH < $clog2(CHANNELS)) begin : g_bad_idx_w
    $error("CH_IDX_WIDTH too narrow for CHANNELS");
  end

  lsm_state_t                 state_q, state_nxt;
  logic [CHANNELS-1:0]        pending_q, gnt, clr, coll, done_q, ovf_q;
  logic [CH_IDX_WIDTH-1:0]    gnt_idx, ptr_q;
  logic [DW-1:0]              data_q [CHANNELS];
  logic [DW-1:0]              gnt_data;
  logic [CH_IDX_WIDTH+DW-1:0] cdc_data_q;
  logic                       req_q, grant_fire, ack_fire;

  cdnsusbhs_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (CH_IDX_WIDTH)
  ) u_arb (
    .req     (pending_q),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge txclk or negedge txrst) begin
    if (!txrst) state_q <= LSM_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      LSM_IDLE:    if (grant_fire) state_nxt = LSM_REQ;
      LSM_REQ:     if (cdc_ack)    state_nxt = LSM_ACKWAIT;
      LSM_ACKWAIT: if (!cdc_ack)   state_nxt = LSM_IDLE;
      default:                     state_nxt = LSM_IDLE;
    endcase
  end

  // A high ack in IDLE is stale or a protocol error, so it blocks new grants.
  always_comb begin
    grant_fire = (state_q == LSM_IDLE) && !cdc_ack && (|pending_q);
    ack_fire   = (state_q == LSM_REQ) && cdc_ack;
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      clr[i]  = grant_fire && gnt[i];
      coll[i] = txload[i] && pending_q[i] && !clr[i];
      if (gnt[i]) gnt_data = gnt_data | data_q[i];
    end
  end

  // cdc_req is a flop, not a state decode, so the CDC path never sees a glitch.
  always_ff @(posedge txclk or negedge txrst) begin
    if (!txrst) begin
      pending_q  <= '0;
      done_q     <= '0;
      ovf_q      <= '0;
      req_q      <= 1'b0;
      cdc_data_q <= '0;
      ptr_q      <= CH_IDX_WIDTH'(CHANNELS - 1);
      for (int i = 0; i < int'(CHANNELS); i++) data_q[i] <= '0;
    end else begin
      pending_q <= txload | (pending_q & ~clr);
      ovf_q     <= coll;
      done_q    <= ack_fire ? (CHANNELS'(1) << ptr_q) : '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (txload[i] && (OVERWRITE_EN || !coll[i])) data_q[i] <= txdata[i*DW +: DW];
      end
      if (grant_fire) begin
        cdc_data_q <= {gnt_idx, gnt_data};
        ptr_q      <= gnt_idx;
        req_q      <= 1'b1;
      end else if (ack_fire) begin
        req_q      <= 1'b0;
      end
    end
  end

  assign txpending = pending_q;
  assign txdone    = done_q;
  assign txovf     = ovf_q;
  assign cdc_req   = req_q;
  assign cdc_data  = cdc_data_q;

endmodule

// File: tb/tb_cdnsusbhs_load_sync_mux.sv
// Directed bench: two instances (overwrite and keep policy) share stimulus; ack is driven by hand.
module tb_cdnsusbhs_load_sync_mux;

  logic        txclk = 1'b0;
  logic        txrst = 1'b0;
  logic [3:0]  txload = '0;
  logic [31:0] txdata = '0;
  logic        cdc_ack = 1'b0;

  logic [3:0] txpending, txdone, txovf, txpending_k, txdone_k, txovf_k;
  logic       cdc_req, cdc_req_k;
  logic [9:0] cdc_data, cdc_data_k;

  int n_chk = 0;
  int n_err = 0;

  always #5 txclk = ~txclk;

  cdnsusbhs_load_sync_mux #(
    .DATA_SYNC_WIDTH(8), .CHANNELS(4), .CH_IDX_WIDTH(2), .OVERWRITE_EN(1'b1)
  ) u_dut (
    .txclk(txclk), .txrst(txrst), .txload(txload), .txdata(txdata),
    .txpending(txpending), .txdone(txdone), .txovf(txovf),
    .cdc_req(cdc_req), .cdc_data(cdc_data), .cdc_ack(cdc_ack)
  );

  cdnsusbhs_load_sync_mux #(
    .DATA_SYNC_WIDTH(8), .CHANNELS(4), .CH_IDX_WIDTH(2), .OVERWRITE_EN(1'b0)
  ) u_dut_k (
    .txclk(txclk), .txrst(txrst), .txload(txload), .txdata(txdata),
    .txpending(txpending_k), .txdone(txdone_k), .txovf(txovf_k),
    .cdc_req(cdc_req_k), .cdc_data(cdc_data_k), .cdc_ack(cdc_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    txrst   = 1'b0;
    txload  = '0;
    cdc_ack = 1'b0;
    @(negedge txclk);
    @(negedge txclk);
    txrst = 1'b1;
    @(negedge txclk);
  endtask

  task automatic set_load(input int ch, input logic [7:0] d);
    txload[ch]        = 1'b1;
    txdata[ch*8 +: 8] = d;
  endtask

  task automatic xfer_begin(input int idx, input logic [7:0] d, input logic [7:0] dk);
    logic [1:0] t;
    int n;
    t = idx[1:0];
    n = 0;
    while (!cdc_req && n < 20) begin
      @(negedge txclk);
      n++;
    end
    check("req_rise", cdc_req, 1);
    check("req_rise_k", cdc_req_k, 1);
    check("cdc_data", cdc_data, {t, d});
    check("cdc_data_k", cdc_data_k, {t, dk});
  endtask

  task automatic xfer_end(input int idx);
    cdc_ack = 1'b1;
    @(negedge txclk);
    check("req_fall", cdc_req, 0);
    check("txdone", txdone, 32'd1 << idx);
    check("txdone_k", txdone_k, 32'd1 << idx);
    repeat (3) @(negedge txclk);
    check("txdone_single", txdone, 0);
    check("req_low_ack", cdc_req, 0);
    cdc_ack = 1'b0;
    @(negedge txclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_req", cdc_req, 0);
    check("rst_data", cdc_data, 0);
    check("rst_pending", txpending, 0);
    check("rst_done", txdone, 0);
    check("rst_ovf", txovf, 0);
    @(negedge txclk);
    txrst = 1'b1;
    @(negedge txclk);

    // single transfer: req one edge after capture
    set_load(0, 8'hA5);
    @(negedge txclk);
    txload = '0;
    check("single_pending", txpending, 4'b0001);
    check("single_req_early", cdc_req, 0);
    @(negedge txclk);
    check("single_req", cdc_req, 1);
    check("single_pending_clr", txpending, 0);
    xfer_begin(0, 8'hA5, 8'hA5);
    xfer_end(0);

    // round robin 0..3, then 0,2 loaded while 3 in flight
    reset_dut();
    for (int i = 0; i < 4; i++) set_load(i, 8'h10 + 8'(i));
    @(negedge txclk);
    txload = '0;
    check("rr_pending_all", txpending, 4'b1111);
    @(negedge txclk);
    check("rr_pending_g0", txpending, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      xfer_begin(i, 8'h10 + 8'(i), 8'h10 + 8'(i));
      xfer_end(i);
    end
    xfer_begin(3, 8'h13, 8'h13);
    set_load(0, 8'h20);
    set_load(2, 8'h22);
    @(negedge txclk);
    txload = '0;
    check("rr_inflight_ovf", txovf, 0);
    xfer_end(3);
    xfer_begin(0, 8'h20, 8'h20);
    xfer_end(0);
    xfer_begin(2, 8'h22, 8'h22);
    xfer_end(2);

    // collision on channel 1 while channel 0 is busy
    reset_dut();
    set_load(0, 8'h30);
    @(negedge txclk);
    txload = '0;
    xfer_begin(0, 8'h30, 8'h30);
    set_load(1, 8'h01);
    @(negedge txclk);
    txload = '0;
    check("coll_first_ovf", txovf, 0);
    set_load(1, 8'h02);
    @(negedge txclk);
    txload = '0;
    check("coll_ovf", txovf, 4'b0010);
    check("coll_ovf_k", txovf_k, 4'b0010);
    @(negedge txclk);
    check("coll_ovf_pulse", txovf, 0);
    xfer_end(0);
    xfer_begin(1, 8'h02, 8'h01);
    xfer_end(1);

    // load on the grant edge of channel 2
    reset_dut();
    set_load(2, 8'h40);
    @(negedge txclk);
    set_load(2, 8'h41);
    @(negedge txclk);
    txload = '0;
    check("same_req", cdc_req, 1);
    check("same_data", cdc_data, {2'd2, 8'h40});
    check("same_pending", txpending, 4'b0100);
    check("same_ovf", txovf, 0);
    check("same_ovf_k", txovf_k, 0);
    xfer_end(2);
    xfer_begin(2, 8'h41, 8'h41);
    xfer_end(2);

    // stale ack holds off the grant
    reset_dut();
    cdc_ack = 1'b1;
    set_load(0, 8'h55);
    @(negedge txclk);
    txload = '0;
    repeat (3) @(negedge txclk);
    check("stale_req", cdc_req, 0);
    check("stale_pending", txpending, 4'b0001);
    cdc_ack = 1'b0;
    @(negedge txclk);
    check("stale_release_req", cdc_req, 1);
    xfer_begin(0, 8'h55, 8'h55);
    xfer_end(0);

    // reset mid-REQ clears everything asynchronously
    reset_dut();
    set_load(1, 8'h66);
    set_load(3, 8'h67);
    @(negedge txclk);
    txload = '0;
    xfer_begin(1, 8'h66, 8'h66);
    check("mid_pending", txpending, 4'b1000);
    #2 txrst = 1'b0;
    #1;
    check("arst_req", cdc_req, 0);
    check("arst_pending", txpending, 0);
    check("arst_data", cdc_data, 0);
    @(negedge txclk);
    txrst = 1'b1;
    set_load(3, 8'h77);
    @(negedge txclk);
    txload = '0;
    xfer_begin(3, 8'h77, 8'h77);
    xfer_end(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
